mantissa_pp_gen: RTL and testbench
==================================

# mantissa_pp_gen

Two-stage pipelined partial-product generator that feeds the 28x28 mantissa Wallace-tree compressor in the FMAU multiplier path. It accepts two 28-bit mantissas and a precision mode, splits each operand into four 7-bit digits and forms the sixteen 7x7 digit products. It zeroes the cross terms that must not contribute in split-precision modes and presents the products, registered, with a valid/ready handshake. The sixteen product outputs map one-to-one onto the tree's PP11..PP44 inputs. The op code is forwarded alongside them so the tree's final adder can select carry-through.

## Interface
Parameters: none (widths fixed by the 28x28 tree).

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of both pipeline stages (valids only)
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  28  mantissa A, digits a1=a[6:0], a2=a[13:7], a3=a[20:14], a4=a[27:21]
- b  input  28  mantissa B, digits b1..b4 likewise
- op  input  2  mode: 00/01 single 28x28; 10 dual 14x14; 11 quad 7x7
- out_valid  output  1  products valid
- out_ready  input  1  downstream tree accepts products
- op_out  output  2  op of the beat being presented
- ppIJ  output  14 each (pp11..pp44, 16 ports)  ppIJ = aI*bJ, weight 2^(7(I+J-2))

## Operation
- Stage S1 register: captures a, b, op on an accepted input beat (in_valid & in_ready); s1_valid set.
- Stage S2 register: on S1→S2 transfer computes all ppIJ from S1 digits and applies the mask; s2_valid set.
- Mask, where the condition true means the product is forced to 14'h0:
  - op 00/01: no products zeroed; op 01 behaves exactly as 00 in this block.
  - op 10: zero pp13, pp14, pp23, pp24, pp31, pp32, pp41, pp42. The low lane is a[13:0]*b[13:0]; the high lane is a[27:14]*b[27:14].
  - op 11: zero all ppIJ with I≠J. Four independent 7x7 lanes.
- Products are unsigned, exact 14 bits (max 127*127 = 16129 = 14'h3F01); no truncation.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = s1_valid & s2_adv.
  - in_ready = !s1_valid | s2_adv.
  - Ready is a combinational path from out_ready; valids are registered.
- Beats are never dropped or duplicated; order is preserved.
- Output data (ppIJ, op_out) and out_valid must hold stable while out_valid & !out_ready.
- S2 data registers load only when s1_adv. S1 data registers load only on an accepted beat. Otherwise they hold.
- flush: clears s1_valid and s2_valid next edge and takes priority over any same-cycle accept. Data registers are don't-care.

## Timing
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, in_ready=1 after release, op_out=2'b00, all ppIJ=14'h0.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1, given no stall.
- Throughput: one beat per cycle with out_ready held high.
- Full (both stages valid, out_ready=0): in_ready=0. Taking out_ready high raises in_ready in the same cycle, and a new beat may be accepted that edge.
- Simultaneous S2 drain, S1→S2 move and new input accept in one edge is legal and required.
- Reset asserted mid-stream: in-flight beats are discarded and outputs go to reset values immediately (asynchronously).
- The op of each beat travels with its data; a mode change between consecutive beats needs no bubble.

## Test plan
- Reset, then a=28'hFFFFFFF, b=28'hFFFFFFF, op=00, out_ready=1 → out_valid 2 cycles after accept; all 16 pp = 14'h3F01; op_out=00.
- Same operands, op=11 → pp11=pp22=pp33=pp44=14'h3F01, other 12 = 0; op=10 → pp11,pp12,pp21,pp22,pp33,pp34,pp43,pp44 = 14'h3F01, rest 0.
- a=28'h0000083 (a1=3,a2=1), b=28'h0000105 (b1=5,b2=2), op=00 → pp11=15, pp12=6, pp21=5, pp22=2, all others 0. Check against the reference model Σ ppIJ·2^(7(I+J-2)) = a*b.
- Backpressure: stream 5 beats with random op and hold out_ready=0 for 4 cycles → in_ready falls after 2 accepted beats; outputs stay stable; all 5 beats arrive in order with no loss or duplication.
- Flush with both stages full and in_valid=1 → next cycle out_valid=0 and s1 empty; the concurrent input beat is not captured.
- Assert rst while out_valid=1 → out_valid and all pp read 0 before the next clock edge; the first post-reset beat emerges with 2-cycle latency.

Source files
------------

// File: rtl/mantissa_pp_gen.sv
// rtl/mantissa_pp_gen.sv - two-stage 7x7 digit partial-product generator feeding the 28x28 mantissa tree
module mantissa_pp_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [27:0] a,
  input  logic [27:0] b,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  op_out,
  output logic [13:0] pp11,
  output logic [13:0] pp12,
  output logic [13:0] pp13,
  output logic [13:0] pp14,
  output logic [13:0] pp21,
  output logic [13:0] pp22,
  output logic [13:0] pp23,
  output logic [13:0] pp24,
  output logic [13:0] pp31,
  output logic [13:0] pp32,
  output logic [13:0] pp33,
  output logic [13:0] pp34,
  output logic [13:0] pp41,
  output logic [13:0] pp42,
  output logic [13:0] pp43,
  output logic [13:0] pp44
);

  localparam logic [1:0] OP_DUAL = 2'b10;
  localparam logic [1:0] OP_QUAD = 2'b11;

  // Pipeline occupancy and handshake terms
  logic        s1_valid;
  logic        s2_valid;
  logic        s2_adv;
  logic        s1_adv;
  logic        in_accept;

  // Stage 1 holds the raw operands; stage 2 holds the masked products
  logic [27:0] s1_a;
  logic [27:0] s1_b;
  logic [1:0]  s1_op;
  logic [1:0]  s2_op;

  // Digit views of the S1 operands and the product array, index (I-1)*4 + (J-1)
  logic [6:0]  a_dig [4];
  logic [6:0]  b_dig [4];
  logic [13:0] pp_next [16];
  logic [13:0] pp_q [16];

  // A cross term survives only when both digits sit in the same lane:
  // dual mode splits digits {1,2} and {3,4}, quad mode gives each digit its own lane.
  function automatic logic pp_keep(input logic [1:0] mode, input logic [1:0] i, input logic [1:0] j);
    case (mode)
      OP_DUAL: pp_keep = (i[1] == j[1]);
      OP_QUAD: pp_keep = (i == j);
      default: pp_keep = 1'b1;
    endcase
  endfunction

  // Ready is combinational from out_ready so a full pipe can refill on the drain edge
  always_comb begin
    s2_adv    = !s2_valid || out_ready;
    s1_adv    = s1_valid && s2_adv;
    in_ready  = !s1_valid || s2_adv;
    in_accept = in_valid && in_ready && !flush;
  end

  // Split the S1 operands into digits and form the sixteen masked 7x7 products
  always_comb begin
    for (int d = 0; d < 4; d++) begin
      a_dig[d] = s1_a[7*d +: 7];
      b_dig[d] = s1_b[7*d +: 7];
    end
    for (int k = 0; k < 16; k++) begin
      if (pp_keep(s1_op, 2'(k / 4), 2'(k % 4))) begin
        pp_next[k] = {7'd0, a_dig[k / 4]} * {7'd0, b_dig[k % 4]};
      end else begin
        pp_next[k] = 14'h0;
      end
    end
  end

  // Valid bits: flush wins over any same-cycle accept or advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (in_ready) begin
        s1_valid <= in_valid;
      end
    end
  end

  // S1 data registers load only on an accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a  <= 28'h0;
      s1_b  <= 28'h0;
      s1_op <= 2'b00;
    end else if (in_accept) begin
      s1_a  <= a;
      s1_b  <= b;
      s1_op <= op;
    end
  end

  // S2 data registers load only when the S1 beat moves forward; held while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_op <= 2'b00;
      for (int k = 0; k < 16; k++) begin
        pp_q[k] <= 14'h0;
      end
    end else if (s1_adv && !flush) begin
      s2_op <= s1_op;
      for (int k = 0; k < 16; k++) begin
        pp_q[k] <= pp_next[k];
      end
    end
  end

  assign out_valid = s2_valid;
  assign op_out    = s2_op;

  assign pp11 = pp_q[0];
  assign pp12 = pp_q[1];
  assign pp13 = pp_q[2];
  assign pp14 = pp_q[3];
  assign pp21 = pp_q[4];
  assign pp22 = pp_q[5];
  assign pp23 = pp_q[6];
  assign pp24 = pp_q[7];
  assign pp31 = pp_q[8];
  assign pp32 = pp_q[9];
  assign pp33 = pp_q[10];
  assign pp34 = pp_q[11];
  assign pp41 = pp_q[12];
  assign pp42 = pp_q[13];
  assign pp43 = pp_q[14];
  assign pp44 = pp_q[15];

endmodule

// File: tb/tb_mantissa_pp_gen.sv
// tb/tb_mantissa_pp_gen.sv - self-checking bench for mantissa_pp_gen
module tb_mantissa_pp_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] a;
  logic [27:0] b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  op_out;
  logic [13:0] pp11, pp12, pp13, pp14, pp21, pp22, pp23, pp24;
  logic [13:0] pp31, pp32, pp33, pp34, pp41, pp42, pp43, pp44;
  logic [223:0] pp_vec;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rx  = 0;

  localparam logic [13:0] X = 14'h3F01;
  localparam logic [13:0] Z = 14'h0;

  typedef struct {
    logic [27:0]  a;
    logic [27:0]  b;
    logic [1:0]   op;
    logic [223:0] exp;
  } vec_t;

  typedef struct {
    logic [223:0] pp;
    logic [1:0]   op;
    logic [27:0]  a;
    logic [27:0]  b;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[7];

  mantissa_pp_gen dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .op_out(op_out),
    .pp11(pp11), .pp12(pp12), .pp13(pp13), .pp14(pp14),
    .pp21(pp21), .pp22(pp22), .pp23(pp23), .pp24(pp24),
    .pp31(pp31), .pp32(pp32), .pp33(pp33), .pp34(pp34),
    .pp41(pp41), .pp42(pp42), .pp43(pp43), .pp44(pp44)
  );

  assign pp_vec = {pp11, pp12, pp13, pp14, pp21, pp22, pp23, pp24,
                   pp31, pp32, pp33, pp34, pp41, pp42, pp43, pp44};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [223:0] act, input logic [223:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Each digit belongs to a lane; products pairing digits of different lanes are zero
  function automatic logic [223:0] model(input logic [27:0] ma, input logic [27:0] mb, input logic [1:0] mop);
    logic [223:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int li;
        int lj;
        int unsigned p;
        li = (mop == 2'b11) ? i : (mop == 2'b10) ? i / 2 : 0;
        lj = (mop == 2'b11) ? j : (mop == 2'b10) ? j / 2 : 0;
        p  = ((ma >> (7 * i)) & 28'h7F) * ((mb >> (7 * j)) & 28'h7F);
        if (li != lj) p = 0;
        v[(15 - (i * 4 + j)) * 14 +: 14] = p[13:0];
      end
    end
    return v;
  endfunction

  // Recombine a square block of digit products into the integer product it represents
  function automatic logic [63:0] wsum(input logic [223:0] v, input int lo, input int hi);
    logic [63:0] s;
    s = '0;
    for (int i = lo; i <= hi; i++) begin
      for (int j = lo; j <= hi; j++) begin
        s += 64'(v[(15 - (i * 4 + j)) * 14 +: 14]) << (7 * ((i - lo) + (j - lo)));
      end
    end
    return s;
  endfunction

  // One cycle: drive at negedge, evaluate the handshake just after, scoreboard the edge to come
  task automatic step(input logic iv, input logic [27:0] ia, input logic [27:0] ib,
                      input logic [1:0] iop, input logic ordy, input logic fl, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    op        = iop;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (out_valid && out_ready && !fl) begin
      if (sbq.size() == 0) begin
        chk("unexpected_beat", 224'(1), 224'(0));
      end else begin
        e = sbq.pop_front();
        n_rx++;
        chk("pp_model", pp_vec, e.pp);
        chk("op_out", 224'(op_out), 224'(e.op));
        if (e.op[1] == 1'b0) begin
          chk("sum_full", 224'(wsum(pp_vec, 0, 3)), 224'(64'(e.a) * 64'(e.b)));
        end else if (e.op == 2'b10) begin
          chk("sum_lo", 224'(wsum(pp_vec, 0, 1)), 224'(64'(e.a[13:0]) * 64'(e.b[13:0])));
          chk("sum_hi", 224'(wsum(pp_vec, 2, 3)), 224'(64'(e.a[27:14]) * 64'(e.b[27:14])));
        end
      end
    end
    acc = in_valid && in_ready && !fl;
    if (acc) begin
      e.pp = model(in_valid ? a : 28'h0, b, op);
      e.op = op;
      e.a  = a;
      e.b  = b;
      sbq.push_back(e);
    end
    if (fl) sbq.delete();
  endtask

  initial begin
    logic         acc;
    int           lat;
    int           idx;
    int           rx0;
    logic [223:0] held;
    logic [27:0]  ba [5];
    logic [27:0]  bb [5];
    logic [1:0]   bo [5];

    tbl[0] = '{a: 28'hFFFFFFF, b: 28'hFFFFFFF, op: 2'b00, exp: {16{X}}};
    tbl[1] = '{a: 28'hFFFFFFF, b: 28'hFFFFFFF, op: 2'b01, exp: {16{X}}};
    tbl[2] = '{a: 28'hFFFFFFF, b: 28'hFFFFFFF, op: 2'b11,
               exp: {X, Z, Z, Z, Z, X, Z, Z, Z, Z, X, Z, Z, Z, Z, X}};
    tbl[3] = '{a: 28'hFFFFFFF, b: 28'hFFFFFFF, op: 2'b10,
               exp: {X, X, Z, Z, X, X, Z, Z, Z, Z, X, X, Z, Z, X, X}};
    tbl[4] = '{a: 28'h0000083, b: 28'h0000105, op: 2'b00,
               exp: {14'd15, 14'd6, Z, Z, 14'd5, 14'd2, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z}};
    tbl[5] = '{a: 28'h0000083, b: 28'h0000105, op: 2'b11,
               exp: {14'd15, Z, Z, Z, Z, 14'd2, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z}};
    tbl[6] = '{a: 28'h0000083, b: 28'h0000105, op: 2'b10,
               exp: {14'd15, 14'd6, Z, Z, 14'd5, 14'd2, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z}};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 224'(out_valid), 224'(0));
    chk("rst_in_ready", 224'(in_ready), 224'(1));
    chk("rst_op_out", 224'(op_out), 224'(0));
    chk("rst_pp", pp_vec, 224'(0));

    // Directed vectors with latency measurement
    for (int t = 0; t < 7; t++) begin
      step(1'b1, tbl[t].a, tbl[t].b, tbl[t].op, 1'b1, 1'b0, acc);
      chk("tbl_accept", 224'(acc), 224'(1));
      lat = 0;
      do begin
        step(1'b0, 28'h0, 28'h0, 2'b00, 1'b1, 1'b0, acc);
        lat++;
      end while (!out_valid && lat < 8);
      chk("tbl_latency", 224'(lat), 224'(2));
      chk("tbl_pp", pp_vec, tbl[t].exp);
      chk("tbl_op", 224'(op_out), 224'(tbl[t].op));
    end
    step(1'b0, 28'h0, 28'h0, 2'b00, 1'b1, 1'b0, acc);

    // Backpressure: 5 beats, out_ready low for 4 cycles
    for (int k = 0; k < 5; k++) begin
      ba[k] = 28'($urandom());
      bb[k] = 28'($urandom());
      bo[k] = 2'($urandom_range(0, 3));
    end
    rx0 = n_rx;
    idx = 0;
    held = '0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, ba[idx], bb[idx], bo[idx], 1'b0, 1'b0, acc);
      if (acc) idx++;
      if (c == 2) held = pp_vec;
    end
    chk("bp_accepted", 224'(idx), 224'(2));
    chk("bp_in_ready", 224'(in_ready), 224'(0));
    chk("bp_stable", pp_vec, held);
    for (int c = 0; c < 30 && (idx < 5 || sbq.size() > 0); c++) begin
      if (idx < 5) step(1'b1, ba[idx], bb[idx], bo[idx], 1'b1, 1'b0, acc);
      else         step(1'b0, 28'h0, 28'h0, 2'b00, 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_delivered", 224'(n_rx - rx0), 224'(5));

    // Flush with both stages full and a concurrent input beat
    step(1'b1, 28'h1234567, 28'h7654321, 2'b00, 1'b0, 1'b0, acc);
    step(1'b1, 28'h0ABCDEF, 28'h0FEDCBA, 2'b10, 1'b0, 1'b0, acc);
    step(1'b1, 28'h5555555, 28'h2AAAAAA, 2'b11, 1'b0, 1'b1, acc);
    chk("fl_full_valid", 224'(out_valid), 224'(1));
    chk("fl_full_ready", 224'(in_ready), 224'(0));
    step(1'b0, 28'h0, 28'h0, 2'b00, 1'b0, 1'b0, acc);
    chk("fl_out_valid", 224'(out_valid), 224'(0));
    chk("fl_in_ready", 224'(in_ready), 224'(1));
    step(1'b0, 28'h0, 28'h0, 2'b00, 1'b0, 1'b0, acc);
    chk("fl_s1_empty", 224'(out_valid), 224'(0));
    step(1'b1, 28'h00FF0FF, 28'h0F0F0F0, 2'b01, 1'b1, 1'b0, acc);
    for (int c = 0; c < 6; c++) step(1'b0, 28'h0, 28'h0, 2'b00, 1'b1, 1'b0, acc);

    // Randomized stream
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, 28'($urandom()), 28'($urandom()),
           2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, 1'b0, acc);
    end
    for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
      step(1'b0, 28'h0, 28'h0, 2'b00, 1'b1, 1'b0, acc);
    end
    chk("rand_drained", 224'(sbq.size()), 224'(0));

    // Reset mid-stream, then post-reset latency
    step(1'b1, 28'hFFFFFFF, 28'hFFFFFFF, 2'b00, 1'b0, 1'b0, acc);
    step(1'b1, 28'h1111111, 28'h2222222, 2'b10, 1'b0, 1'b0, acc);
    step(1'b0, 28'h0, 28'h0, 2'b00, 1'b0, 1'b0, acc);
    chk("mid_out_valid", 224'(out_valid), 224'(1));
    rst = 1'b1;
    #1;
    chk("async_out_valid", 224'(out_valid), 224'(0));
    chk("async_pp", pp_vec, 224'(0));
    chk("async_op_out", 224'(op_out), 224'(0));
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    step(1'b1, 28'h0000083, 28'h0000105, 2'b00, 1'b1, 1'b0, acc);
    chk("post_accept", 224'(acc), 224'(1));
    step(1'b0, 28'h0, 28'h0, 2'b00, 1'b1, 1'b0, acc);
    chk("post_lat1", 224'(out_valid), 224'(0));
    step(1'b0, 28'h0, 28'h0, 2'b00, 1'b1, 1'b0, acc);
    chk("post_lat2", 224'(out_valid), 224'(1));
    chk("post_pp", pp_vec, {14'd15, 14'd6, Z, Z, 14'd5, 14'd2, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
